// File: rtl/dispatch_pkg.sv
// Shared definitions for the credit-based dispatch stage: FU type codes,
// the default port-to-type map and the credit counter width helper.
package dispatch_pkg;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MDU  = 2'd1,
    FU_MEM  = 2'd2,
    FU_MISC = 2'd3
  } fu_type_e;

  // Port 0 is the low field: ports 0,1 = ALU, 2 = MDU, 3 = MEM, 4 = MISC.
  localparam logic [9:0] DEFAULT_PORT_TYPE = {2'd3, 2'd2, 2'd1, 2'd0, 2'd0};

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-port reservation-station credit counter; saturates at RS_DEPTH and
// flags an overflow when a return arrives with the counter already full.
module credit_counter
  import dispatch_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int CNT_W    = credit_width(RS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RS_DEPTH);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (flush_i) begin
      count_d = FULL;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end else if (inc_i && !dec_i) begin
      if (count_q == FULL) begin
        ovf_o = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/credit_dispatch_unit.sv
// In-order dispatch of up to DISPATCH_WIDTH queue-head entries onto typed
// RS write ports, gated by per-port credits; RS writes are registered.
module credit_dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 4,
  parameter int NUM_PORTS      = 5,
  parameter int TYPE_W         = 2,
  parameter logic [NUM_PORTS*TYPE_W-1:0] PORT_TYPE = DEFAULT_PORT_TYPE,
  parameter int RS_DEPTH       = 8,
  parameter int DATA_W         = 128,
  localparam int CNT_W         = credit_width(RS_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic [DISPATCH_WIDTH-1:0]        in_valid_i,
  input  logic [DISPATCH_WIDTH*TYPE_W-1:0] in_type_i,
  input  logic [DISPATCH_WIDTH*DATA_W-1:0] in_data_i,
  output logic [DISPATCH_WIDTH-1:0]        in_ready_o,
  input  logic [NUM_PORTS-1:0]             credit_ret_i,
  output logic [NUM_PORTS-1:0]             out_valid_o,
  output logic [NUM_PORTS*DATA_W-1:0]      out_data_o,
  output logic [NUM_PORTS*CNT_W-1:0]       credit_o,
  output logic                             err_o
);

  // Handshake: in_ready_o[i] is combinational and asserted only together with
  // in_valid_i[i]; slot i is consumed at this clock edge and the queue pops
  // exactly the asserted slots, which always form a prefix starting at slot 0.

  logic [NUM_PORTS-1:0]        out_valid_q, out_valid_d;
  logic [NUM_PORTS*DATA_W-1:0] out_data_q, out_data_d;
  logic                        err_q, err_d;
  logic [NUM_PORTS-1:0]        dispatch;
  logic [NUM_PORTS-1:0]        ovf;
  logic [NUM_PORTS-1:0]        taken;
  logic [CNT_W-1:0]            credit_w [NUM_PORTS];
  logic                        chain;
  logic                        found;
  logic                        routable;
  logic                        unroutable;
  int                          pidx;

  always_comb begin
    taken      = '0;
    in_ready_o = '0;
    out_data_d = out_data_q;
    chain      = !flush_i;
    unroutable = 1'b0;
    found      = 1'b0;
    routable   = 1'b0;
    pidx       = 0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      found    = 1'b0;
      routable = 1'b0;
      pidx     = 0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (PORT_TYPE[p*TYPE_W +: TYPE_W] == in_type_i[i*TYPE_W +: TYPE_W]) begin
          routable = 1'b1;
          if (!found && !taken[p] && (credit_w[p] != '0)) begin
            found = 1'b1;
            pidx  = p;
          end
        end
      end
      if (chain && in_valid_i[i] && !routable) begin
        unroutable = 1'b1;
      end
      if (chain && in_valid_i[i] && found) begin
        in_ready_o[i] = 1'b1;
        taken[pidx]   = 1'b1;
        out_data_d[pidx*DATA_W +: DATA_W] = in_data_i[i*DATA_W +: DATA_W];
      end
      chain = chain & in_ready_o[i];
    end
    dispatch    = taken;
    out_valid_d = taken;
    err_d       = err_q | unroutable | (|ovf);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_credit
    credit_counter #(
      .RS_DEPTH(RS_DEPTH),
      .CNT_W   (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush_i(flush_i),
      .dec_i  (dispatch[p]),
      .inc_i  (credit_ret_i[p]),
      .count_o(credit_w[p]),
      .ovf_o  (ovf[p])
    );
    assign credit_o[p*CNT_W +: CNT_W] = credit_w[p];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_credit_dispatch_unit.sv
// Directed bench for credit_dispatch_unit: routing, in-order stall, credit
// exhaustion/return, saturation error, flush and mid-stream reset.
module tb_credit_dispatch_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [7:0]   in_type = '0;
  logic [511:0] in_data = '0;
  logic [3:0]   in_ready;
  logic [4:0]   ret = '0;
  logic [4:0]   out_valid;
  logic [639:0] out_data;
  logic [19:0]  credit;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  credit_dispatch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_type_i   (in_type),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .credit_ret_i(ret),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .credit_o    (credit),
    .err_o       (err)
  );

  function automatic logic [3:0] cred(input int p);
    return credit[p*4 +: 4];
  endfunction

  function automatic logic [127:0] odata(input int p);
    return out_data[p*128 +: 128];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [1:0] t, input logic [127:0] d);
    in_type[i*2 +: 2]     = t;
    in_data[i*128 +: 128] = d;
  endtask

  task automatic idle();
    in_valid = '0;
    ret      = '0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL reset_out_valid got %b want %b", out_valid, 5'b00000); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got %h want 0", odata(0)); end
    for (int p = 0; p < 5; p++) begin
      n_cmp++; if (cred(p) !== 4'd8) begin n_err++; $display("FAIL reset_credit[%0d] got %0d want 8", p, cred(p)); end
    end
  endtask

  task automatic test_mixed();
    logic [3:0] exp_c [5];
    exp_c = '{4'd7, 4'd7, 4'd8, 4'd7, 4'd7};
    set_slot(0, 2'd0, 128'hA0);
    set_slot(1, 2'd0, 128'hA1);
    set_slot(2, 2'd2, 128'hA2);
    set_slot(3, 2'd3, 128'hA3);
    in_valid = 4'b1111;
    #1;
    n_cmp++; if (in_ready !== 4'b1111) begin n_err++; $display("FAIL mixed_in_ready got %b want 1111", in_ready); end
    tick();
    idle();
    n_cmp++; if (out_valid !== 5'b11011) begin n_err++; $display("FAIL mixed_out_valid got %b want 11011", out_valid); end
    n_cmp++; if (odata(0) !== 128'hA0) begin n_err++; $display("FAIL mixed_data0 got %h want a0", odata(0)); end
    n_cmp++; if (odata(1) !== 128'hA1) begin n_err++; $display("FAIL mixed_data1 got %h want a1", odata(1)); end
    n_cmp++; if (odata(3) !== 128'hA2) begin n_err++; $display("FAIL mixed_data3 got %h want a2", odata(3)); end
    n_cmp++; if (odata(4) !== 128'hA3) begin n_err++; $display("FAIL mixed_data4 got %h want a3", odata(4)); end
    for (int p = 0; p < 5; p++) begin
      n_cmp++; if (cred(p) !== exp_c[p]) begin n_err++; $display("FAIL mixed_credit[%0d] got %0d want %0d", p, cred(p), exp_c[p]); end
    end
    ret = 5'b11011;
    tick();
    idle();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL mixed_idle_valid got %b want 00000", out_valid); end
    n_cmp++; if (odata(0) !== 128'hA0) begin n_err++; $display("FAIL mixed_hold_data0 got %h want a0", odata(0)); end
    for (int p = 0; p < 5; p++) begin
      n_cmp++; if (cred(p) !== 4'd8) begin n_err++; $display("FAIL mixed_ret_credit[%0d] got %0d want 8", p, cred(p)); end
    end
  endtask

  task automatic test_alu_overflow();
    set_slot(0, 2'd0, 128'hB0);
    set_slot(1, 2'd0, 128'hB1);
    set_slot(2, 2'd0, 128'hB2);
    in_valid = 4'b0111;
    #1;
    n_cmp++; if (in_ready !== 4'b0011) begin n_err++; $display("FAIL alu3_in_ready got %b want 0011", in_ready); end
    tick();
    set_slot(0, 2'd0, 128'hB2);
    in_valid = 4'b0001;
    n_cmp++; if (out_valid !== 5'b00011) begin n_err++; $display("FAIL alu3_out_valid got %b want 00011", out_valid); end
    n_cmp++; if (odata(0) !== 128'hB0 || odata(1) !== 128'hB1) begin n_err++; $display("FAIL alu3_data got %h/%h want b0/b1", odata(0), odata(1)); end
    n_cmp++; if (cred(0) !== 4'd7 || cred(1) !== 4'd7) begin n_err++; $display("FAIL alu3_credit got %0d/%0d want 7/7", cred(0), cred(1)); end
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL alu3_retry_ready got %b want 0001", in_ready); end
    tick();
    idle();
    n_cmp++; if (out_valid !== 5'b00001) begin n_err++; $display("FAIL alu3_retry_valid got %b want 00001", out_valid); end
    n_cmp++; if (odata(0) !== 128'hB2) begin n_err++; $display("FAIL alu3_retry_data got %h want b2", odata(0)); end
    n_cmp++; if (cred(0) !== 4'd6 || cred(1) !== 4'd7) begin n_err++; $display("FAIL alu3_retry_credit got %0d/%0d want 6/7", cred(0), cred(1)); end
    ret = 5'b00011;
    tick();
    ret = 5'b00001;
    tick();
    idle();
    n_cmp++; if (cred(0) !== 4'd8 || cred(1) !== 4'd8) begin n_err++; $display("FAIL alu3_restore got %0d/%0d want 8/8", cred(0), cred(1)); end
  endtask

  task automatic test_mdu_exhaust();
    set_slot(0, 2'd1, 128'hC0);
    in_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL mdu_ready[%0d] got %b want 0001", k, in_ready); end
      tick();
    end
    n_cmp++; if (cred(2) !== 4'd0) begin n_err++; $display("FAIL mdu_empty_credit got %0d want 0", cred(2)); end
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL mdu_no_credit_ready got %b want 0000", in_ready); end
    ret = 5'b00100;
    tick();
    ret = '0;
    n_cmp++; if (out_valid[2] !== 1'b0) begin n_err++; $display("FAIL mdu_stall_valid got %b want 0", out_valid[2]); end
    n_cmp++; if (cred(2) !== 4'd1) begin n_err++; $display("FAIL mdu_ret_credit got %0d want 1", cred(2)); end
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL mdu_ret_ready got %b want 0001", in_ready); end
    tick();
    idle();
    n_cmp++; if (out_valid !== 5'b00100) begin n_err++; $display("FAIL mdu_ret_valid got %b want 00100", out_valid); end
    n_cmp++; if (cred(2) !== 4'd0) begin n_err++; $display("FAIL mdu_final_credit got %0d want 0", cred(2)); end
  endtask

  task automatic test_in_order();
    set_slot(0, 2'd1, 128'hD0);
    set_slot(1, 2'd0, 128'hD1);
    in_valid = 4'b0011;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL order_stall_ready got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL order_stall_valid got %b want 00000", out_valid); end
    set_slot(0, 2'd0, 128'hD2);
    set_slot(2, 2'd0, 128'hD3);
    in_valid = 4'b0101;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL order_gap_ready got %b want 0001", in_ready); end
    tick();
    idle();
    n_cmp++; if (out_valid !== 5'b00001 || odata(0) !== 128'hD2) begin n_err++; $display("FAIL order_gap_out got %b/%h want 00001/d2", out_valid, odata(0)); end
    n_cmp++; if (cred(0) !== 4'd7) begin n_err++; $display("FAIL order_gap_credit got %0d want 7", cred(0)); end
    ret = 5'b00001;
    tick();
    idle();
  endtask

  task automatic test_credit_edge();
    set_slot(0, 2'd0, 128'hE0);
    in_valid = 4'b0001;
    ret = 5'b00001;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL edge_both_ready got %b want 0001", in_ready); end
    tick();
    idle();
    n_cmp++; if (cred(0) !== 4'd8) begin n_err++; $display("FAIL edge_both_credit got %0d want 8", cred(0)); end
    n_cmp++; if (out_valid !== 5'b00001) begin n_err++; $display("FAIL edge_both_valid got %b want 00001", out_valid); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL edge_both_err got %b want 0", err); end
    ret = 5'b00001;
    tick();
    idle();
    n_cmp++; if (cred(0) !== 4'd8) begin n_err++; $display("FAIL edge_sat_credit got %0d want 8", cred(0)); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL edge_sat_err got %b want 1", err); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL edge_sticky_err got %b want 1", err); end
  endtask

  task automatic test_flush();
    set_slot(0, 2'd0, 128'hF0);
    set_slot(1, 2'd0, 128'hF1);
    in_valid = 4'b0011;
    for (int k = 0; k < 5; k++) tick();
    n_cmp++; if (out_valid !== 5'b00011) begin n_err++; $display("FAIL flush_busy_valid got %b want 00011", out_valid); end
    n_cmp++; if (cred(0) !== 4'd3 || cred(1) !== 4'd3) begin n_err++; $display("FAIL flush_pre_credit got %0d/%0d want 3/3", cred(0), cred(1)); end
    set_slot(1, 2'd1, 128'hF2);
    set_slot(2, 2'd2, 128'hF3);
    set_slot(3, 2'd3, 128'hF4);
    in_valid = 4'b1111;
    ret = 5'b11111;
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL flush_ready got %b want 0000", in_ready); end
    tick();
    idle();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL flush_valid got %b want 00000", out_valid); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL flush_err_kept got %b want 1", err); end
    for (int p = 0; p < 5; p++) begin
      n_cmp++; if (cred(p) !== 4'd8) begin n_err++; $display("FAIL flush_credit[%0d] got %0d want 8", p, cred(p)); end
    end
    set_slot(0, 2'd0, 128'h55);
    in_valid = 4'b0001;
    tick();
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    idle();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_mid_err got %b want 0", err); end
    n_cmp++; if (out_valid !== 5'b00000 || out_data !== '0) begin n_err++; $display("FAIL rst_mid_out got %b/%h want 00000/0", out_valid, odata(0)); end
    n_cmp++; if (cred(0) !== 4'd8) begin n_err++; $display("FAIL rst_mid_credit got %0d want 8", cred(0)); end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_alu_overflow();
    test_mdu_exhaust();
    test_in_order();
    test_credit_edge();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
